// File: rtl/mmu_pkg.sv
// Address map and region decode for the banked MMU.
// Pure combinational helpers; no timing of their own.
package mmu_pkg;
    typedef enum logic [2:0] {
        RG_NONE, RG_ROM, RG_STD, RG_EXT, RG_DK, RG_RV0, RG_RV1
    } region_e;

    localparam logic [15:0] PAGE_MASK = 16'h0f00;
    localparam logic [15:0] ROM_TOP   = 16'h0200;
    localparam logic [15:0] PG_DISP   = 16'h0900;
    localparam logic [15:0] PG_KBD    = 16'h0d00;
    localparam logic [15:0] PG_EXT    = 16'h0b00;
    localparam logic [15:0] PG_STD    = 16'h0f00;
    localparam logic [15:0] RV0_TOP   = 16'h0800;
    localparam logic [15:0] RV1_LO    = 16'h1200;
    localparam logic [15:0] RV1_TOP   = 16'h1800;

    // Page regions are matched on the masked page; the two VDU windows on the full address.
    function automatic region_e decode(input logic [15:0] a, input logic [15:0] vdu_base);
        logic [15:0] page;
        page = a & PAGE_MASK;
        if (page < ROM_TOP)                          return RG_ROM;
        if (page == PG_STD)                          return RG_STD;
        if (page == PG_EXT)                          return RG_EXT;
        if (page == PG_DISP || page == PG_KBD)       return RG_DK;
        if (a >= vdu_base && a < RV0_TOP)            return RG_RV0;
        if (a >= RV1_LO && a < RV1_TOP)              return RG_RV1;
        return RG_NONE;
    endfunction
endpackage

// File: rtl/mmu_banked_if.sv
// Bus bundle between the CPU/display/keyboard/VDU clients and the MMU.
// Strobe-based, no backpressure: every strobe is accepted in its cycle.
interface mmu_banked_if;
    logic [15:0] core_addr;
    logic        core_write_en;
    logic        core_read_en;
    logic [7:0]  core_write_data;
    logic [7:0]  core_read_data;
    logic        core_read_valid;
    logic        display_read_en;
    logic [3:0]  display_addr;
    logic [7:0]  display_data_out;
    logic        display_data_valid;
    logic        kbd_write_en;
    logic [3:0]  kbd_addr;
    logic [2:0]  kbd_bit;
    logic        kbd_pressed;
    logic        vdu_read_en;
    logic [15:0] vdu_addr;
    logic [7:0]  vdu_data_out;
    logic        vdu_data_valid;
    logic [7:0]  leds;

    modport master (
        output core_addr, core_write_en, core_read_en, core_write_data,
               display_read_en, display_addr, kbd_write_en, kbd_addr, kbd_bit,
               kbd_pressed, vdu_read_en, vdu_addr,
        input  core_read_data, core_read_valid, display_data_out, display_data_valid,
               vdu_data_out, vdu_data_valid, leds
    );
    modport slave (
        input  core_addr, core_write_en, core_read_en, core_write_data,
               display_read_en, display_addr, kbd_write_en, kbd_addr, kbd_bit,
               kbd_pressed, vdu_read_en, vdu_addr,
        output core_read_data, core_read_valid, display_data_out, display_data_valid,
               vdu_data_out, vdu_data_valid, leds
    );
endinterface

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write).
// 1-cycle read latency, no backpressure; contents are never reset.
module bram_sdp #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdat_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdat_o
);
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdat_i;
        if (re_i) rdat_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/bram_sqp.sv
// Shared RAM: one write port and two independent registered read ports.
// 1-cycle read latency on both ports, no backpressure; contents are never reset.
module bram_sqp #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdat_i,
    input  logic          re_a_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdat_a_o,
    input  logic          re_b_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdat_b_o
);
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i)   mem_q[waddr_i] <= wdat_i;
        if (re_a_i) rdat_a_o <= mem_q[raddr_a_i];
        if (re_b_i) rdat_b_o <= mem_q[raddr_b_i];
    end
endmodule

// File: rtl/mmu_banked_digit_persist.sv
// One seven-segment digit: segment byte plus a persistence timer reloaded on every write.
// Timer counts down once per clock and saturates at zero; live_o is high while non-zero.
module digit_persist #(
    parameter int unsigned LOAD = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en_i,
    input  logic [7:0] wr_dat_i,
    output logic [7:0] seg_o,
    output logic       live_o
);
    localparam int TW = $clog2(LOAD + 1);

    logic [7:0]    seg_q;
    logic [TW-1:0] tmr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 8'h00;
            tmr_q <= '0;
        end else if (wr_en_i) begin
            seg_q <= wr_dat_i;
            tmr_q <= TW'(LOAD);
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - TW'(1);
        end
    end

    assign seg_o  = seg_q;
    assign live_o = (tmr_q != '0);
endmodule

// File: rtl/mmu_banked.sv
// Banked memory map: ROM, two RAMs, two VDU windows, display digits, keyboard rows and LED latch.
// Core, display and VDU reads all return 1 cycle after their strobe; no backpressure.
module mmu_banked
    import mmu_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_MHZ = 50,
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned PERSIST_US     = 2000,
    parameter int unsigned KBD_STICKY     = 1,
    parameter string       ROM_INIT_F     = "",
    parameter string       STD_RAM_INIT_F = "",
    parameter string       EXT_RAM_INIT_F = "",
    parameter string       VDU_RAM_INIT_F = "",
    parameter logic [15:0] VDU_BASE_ADDR  = 16'h0200,
    parameter logic [15:0] LED_BASE_ADDR  = 16'h0000
) (
    input logic         clk,
    input logic         rst_n,
    mmu_banked_if.slave bus
);
    localparam int unsigned LOAD      = PERSIST_US * CLOCK_FREQ_MHZ;
    localparam bit          ROM_EMPTY = (ROM_INIT_F == "");

    region_e   rg, rg_q;
    logic [3:0] dk_idx;
    logic       wr, rd, led_hit, rd_vld_q, vdu_in, vdu_in_q, vdu_vld_q, dsp_vld_q;
    logic [7:0] leds_q, kbd_sel, kbd_q, dsp_sel, dsp_dat_q, rd_mux;
    logic [7:0] rom_rdat, std_rdat, ext_rdat, rv0_rdat, rv1_rdat, vdu_rdat;
    logic [7:0] row_q [NUM_DIGITS];
    logic [7:0] row_d [NUM_DIGITS];
    logic [7:0] rel_q [NUM_DIGITS];
    logic [7:0] rel_d [NUM_DIGITS];
    logic [7:0] seg   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] live, dig_we;

    assign rg      = decode(bus.core_addr, VDU_BASE_ADDR);
    assign dk_idx  = bus.core_addr[3:0];
    assign wr      = bus.core_write_en;
    assign rd      = bus.core_read_en;
    assign led_hit = wr && (bus.core_addr == LED_BASE_ADDR);
    assign vdu_in  = (bus.vdu_addr >= VDU_BASE_ADDR) && (bus.vdu_addr < RV0_TOP);

    bram_sdp #(.AW(9)) u_rom (
        .clk, .we_i(1'b0), .waddr_i(9'h000), .wdat_i(8'h00),
        .re_i(rd && rg == RG_ROM), .raddr_i(bus.core_addr[8:0]), .rdat_o(rom_rdat));
    bram_sdp #(.AW(8)) u_std (
        .clk, .we_i(wr && rg == RG_STD), .waddr_i(bus.core_addr[7:0]), .wdat_i(bus.core_write_data),
        .re_i(rd && rg == RG_STD), .raddr_i(bus.core_addr[7:0]), .rdat_o(std_rdat));
    bram_sdp #(.AW(8)) u_ext (
        .clk, .we_i(wr && rg == RG_EXT), .waddr_i(bus.core_addr[7:0]), .wdat_i(bus.core_write_data),
        .re_i(rd && rg == RG_EXT), .raddr_i(bus.core_addr[7:0]), .rdat_o(ext_rdat));
    bram_sdp #(.AW(11)) u_rv1 (
        .clk, .we_i(wr && rg == RG_RV1), .waddr_i(bus.core_addr[10:0]), .wdat_i(bus.core_write_data),
        .re_i(rd && rg == RG_RV1), .raddr_i(bus.core_addr[10:0]), .rdat_o(rv1_rdat));
    bram_sqp #(.AW(11)) u_rv0 (
        .clk, .we_i(wr && rg == RG_RV0), .waddr_i(bus.core_addr[10:0]), .wdat_i(bus.core_write_data),
        .re_a_i(rd && rg == RG_RV0), .raddr_a_i(bus.core_addr[10:0]), .rdat_a_o(rv0_rdat),
        .re_b_i(bus.vdu_read_en && vdu_in), .raddr_b_i(bus.vdu_addr[10:0]), .rdat_b_o(vdu_rdat));

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        assign dig_we[i] = wr && !led_hit && (rg == RG_DK) && (dk_idx == 4'(i));
        digit_persist #(.LOAD(LOAD)) u_dig (
            .clk, .rst_n, .wr_en_i(dig_we[i]), .wr_dat_i(bus.core_write_data),
            .seg_o(seg[i]), .live_o(live[i]));
    end

    always_comb begin
        kbd_sel = 8'hff;
        dsp_sel = 8'h00;
        for (int r = 0; r < NUM_DIGITS; r++) begin
            if (dk_idx == 4'(r)) kbd_sel = row_q[r];
            if (bus.display_addr == 4'(r) && live[r]) dsp_sel = seg[r];
        end
        if ({12'h000, bus.display_addr} == LED_BASE_ADDR) dsp_sel = leds_q;
    end

    // A released key lingers in rel until a core read of its row, which may coincide with the release.
    always_comb begin
        for (int r = 0; r < NUM_DIGITS; r++) begin
            row_d[r] = row_q[r];
            rel_d[r] = rel_q[r];
            if (bus.kbd_write_en && bus.kbd_addr == 4'(r)) begin
                if (bus.kbd_pressed) begin
                    row_d[r][bus.kbd_bit] = 1'b0;
                    rel_d[r][bus.kbd_bit] = 1'b0;
                end else if (KBD_STICKY != 0) begin
                    rel_d[r][bus.kbd_bit] = 1'b1;
                end else begin
                    row_d[r][bus.kbd_bit] = 1'b1;
                end
            end
            if (rd && rg == RG_DK && dk_idx == 4'(r)) begin
                row_d[r] = row_d[r] | rel_d[r];
                rel_d[r] = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_q    <= 8'h00;
            rd_vld_q  <= 1'b0;
            rg_q      <= RG_NONE;
            kbd_q     <= 8'hff;
            dsp_vld_q <= 1'b0;
            dsp_dat_q <= 8'h00;
            vdu_vld_q <= 1'b0;
            vdu_in_q  <= 1'b0;
            for (int r = 0; r < NUM_DIGITS; r++) begin
                row_q[r] <= 8'hff;
                rel_q[r] <= 8'h00;
            end
        end else begin
            if (led_hit) leds_q <= bus.core_write_data;
            rd_vld_q  <= rd;
            rg_q      <= rd ? rg : RG_NONE;
            if (rd) kbd_q <= kbd_sel;
            dsp_vld_q <= bus.display_read_en;
            if (bus.display_read_en) dsp_dat_q <= dsp_sel;
            vdu_vld_q <= bus.vdu_read_en;
            if (bus.vdu_read_en) vdu_in_q <= vdu_in;
            for (int r = 0; r < NUM_DIGITS; r++) begin
                row_q[r] <= row_d[r];
                rel_q[r] <= rel_d[r];
            end
        end
    end

    always_comb begin
        case (rg_q)
            RG_ROM:  rd_mux = ROM_EMPTY ? 8'h00 : rom_rdat;
            RG_STD:  rd_mux = std_rdat;
            RG_EXT:  rd_mux = ext_rdat;
            RG_RV0:  rd_mux = rv0_rdat;
            RG_RV1:  rd_mux = rv1_rdat;
            RG_DK:   rd_mux = kbd_q;
            default: rd_mux = 8'h00;
        endcase
    end

    assign bus.core_read_data     = rd_vld_q ? rd_mux : 8'h00;
    assign bus.core_read_valid    = rd_vld_q;
    assign bus.display_data_out   = dsp_dat_q;
    assign bus.display_data_valid = dsp_vld_q;
    assign bus.vdu_data_out       = (vdu_vld_q && vdu_in_q) ? vdu_rdat : 8'h00;
    assign bus.vdu_data_valid     = vdu_vld_q;
    assign bus.leds               = leds_q;
endmodule

// File: tb/tb_mmu_banked.sv
// Directed bench for mmu_banked with a short persistence window (20 us at 5 MHz = 100 cycles).
module tb_mmu_banked;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mmu_banked_if bus();

    mmu_banked #(
        .CLOCK_FREQ_MHZ(5),
        .NUM_DIGITS(8),
        .PERSIST_US(20),
        .KBD_STICKY(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        bus.core_addr       = a;
        bus.core_write_data = d;
        bus.core_write_en   = 1'b1;
        tick();
        bus.core_write_en   = 1'b0;
    endtask

    task automatic cpu_rd(input logic [15:0] a);
        bus.core_addr    = a;
        bus.core_read_en = 1'b1;
        tick();
        bus.core_read_en = 1'b0;
    endtask

    task automatic disp_rd(input logic [3:0] i);
        bus.display_addr    = i;
        bus.display_read_en = 1'b1;
        tick();
        bus.display_read_en = 1'b0;
    endtask

    task automatic kbd_ev(input logic [3:0] row, input logic [2:0] b, input logic p);
        bus.kbd_addr     = row;
        bus.kbd_bit      = b;
        bus.kbd_pressed  = p;
        bus.kbd_write_en = 1'b1;
        tick();
        bus.kbd_write_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.core_addr = '0; bus.core_write_en = 0; bus.core_read_en = 0; bus.core_write_data = '0;
        bus.display_read_en = 0; bus.display_addr = '0;
        bus.kbd_write_en = 0; bus.kbd_addr = '0; bus.kbd_bit = '0; bus.kbd_pressed = 0;
        bus.vdu_read_en = 0; bus.vdu_addr = '0;
        repeat (3) tick();
        check("rst_leds", bus.leds, 16'h00);
        check("rst_core_vld", bus.core_read_valid, 16'h0);
        check("rst_core_dat", bus.core_read_data, 16'h00);
        check("rst_disp_vld", bus.display_data_valid, 16'h0);
        check("rst_disp_dat", bus.display_data_out, 16'h00);
        check("rst_vdu_vld", bus.vdu_data_valid, 16'h0);
        rst_n = 1'b1;
        tick();
        cpu_rd(16'h0d00);
        check("rst_row0", bus.core_read_data, 16'hff);

        // Digit persistence, LED latch, out-of-range digit
        cpu_wr(16'h0903, 8'h5a);
        cpu_wr(16'h0000, 8'h3c);
        check("leds_wr", bus.leds, 16'h3c);
        cpu_wr(16'h090a, 8'hee);
        tick();
        disp_rd(4'd3);
        check("disp3_vld", bus.display_data_valid, 16'h1);
        check("disp3_1us", bus.display_data_out, 16'h5a);
        disp_rd(4'd0);
        check("disp_led", bus.display_data_out, 16'h3c);
        disp_rd(4'd10);
        check("disp_oor", bus.display_data_out, 16'h00);
        cpu_wr(16'h0905, 8'h11);
        bus.core_addr = 16'h0905; bus.core_write_data = 8'h22; bus.core_write_en = 1'b1;
        bus.display_addr = 4'd5; bus.display_read_en = 1'b1;
        tick();
        bus.core_write_en = 1'b0; bus.display_read_en = 1'b0;
        check("disp5_old", bus.display_data_out, 16'h11);
        disp_rd(4'd5);
        check("disp5_new", bus.display_data_out, 16'h22);
        repeat (100) tick();
        disp_rd(4'd3);
        check("disp3_expired", bus.display_data_out, 16'h00);

        // RAM latency, unmapped and ROM reads
        cpu_wr(16'h0f10, 8'h77);
        bus.core_addr = 16'h0f10; bus.core_read_en = 1'b1;
        check("std_vld_pre", bus.core_read_valid, 16'h0);
        tick();
        bus.core_read_en = 1'b0;
        check("std_vld", bus.core_read_valid, 16'h1);
        check("std_dat", bus.core_read_data, 16'h77);
        tick();
        check("std_vld_post", bus.core_read_valid, 16'h0);
        cpu_rd(16'h3000);
        check("rom_3000", bus.core_read_data, 16'h00);
        cpu_wr(16'h0a00, 8'h12);
        cpu_rd(16'h0a00);
        check("unmapped", bus.core_read_data, 16'h00);
        cpu_wr(16'h0b05, 8'h99);
        cpu_rd(16'h0b05);
        check("ext_dat", bus.core_read_data, 16'h99);
        cpu_rd(16'h090a);
        check("kbd_oor", bus.core_read_data, 16'hff);

        // Sticky keyboard
        kbd_ev(4'd2, 3'd4, 1'b1);
        kbd_ev(4'd2, 3'd4, 1'b0);
        cpu_rd(16'h0d02);
        check("kbd_sticky", bus.core_read_data, 16'hef);
        cpu_rd(16'h0d02);
        check("kbd_cleared", bus.core_read_data, 16'hff);
        bus.kbd_addr = 4'd1; bus.kbd_bit = 3'd0; bus.kbd_pressed = 1'b1; bus.kbd_write_en = 1'b1;
        bus.core_addr = 16'h0d01; bus.core_read_en = 1'b1;
        tick();
        bus.kbd_write_en = 1'b0; bus.core_read_en = 1'b0;
        check("kbd_same_cyc", bus.core_read_data, 16'hff);
        cpu_rd(16'h0d01);
        check("kbd_held", bus.core_read_data, 16'hfe);

        // VDU port concurrent with a ROM read
        cpu_wr(16'h0200, 8'h41);
        bus.vdu_addr = 16'h0200; bus.vdu_read_en = 1'b1;
        bus.core_addr = 16'h0010; bus.core_read_en = 1'b1;
        tick();
        bus.vdu_read_en = 1'b0; bus.core_read_en = 1'b0;
        check("vdu_vld", bus.vdu_data_valid, 16'h1);
        check("vdu_dat", bus.vdu_data_out, 16'h41);
        check("rom_concurrent", bus.core_read_valid, 16'h1);
        bus.vdu_addr = 16'h0900; bus.vdu_read_en = 1'b1;
        tick();
        bus.vdu_read_en = 1'b0;
        check("vdu_oor", bus.vdu_data_out, 16'h00);
        cpu_wr(16'h1234, 8'h5e);
        cpu_rd(16'h1234);
        check("rv1_dat", bus.core_read_data, 16'h5e);

        // Reset mid-read
        bus.core_addr = 16'h0f10; bus.core_read_en = 1'b1;
        tick();
        bus.core_read_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_vld", bus.core_read_valid, 16'h0);
        check("midrst_dat", bus.core_read_data, 16'h00);
        check("midrst_leds", bus.leds, 16'h00);
        tick();
        rst_n = 1'b1;
        tick();
        cpu_rd(16'h0d01);
        check("midrst_row1", bus.core_read_data, 16'hff);
        cpu_rd(16'h0f10);
        check("midrst_ram", bus.core_read_data, 16'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mmu_banked.md
MMU_BANKED -- requirements
Module: mmu_banked

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- CLOCK_FREQ_MHZ, 50, clock ticks per microsecond.
- NUM_DIGITS, 8, seven-segment digits and keyboard rows (1..16).
- PERSIST_US, 2000, digit persistence after a write, in microseconds.
- KBD_STICKY, 1, when 1 a keypress stays reported until the core has read that row after release.
- ROM_INIT_F / STD_RAM_INIT_F / EXT_RAM_INIT_F / VDU_RAM_INIT_F, "", memory init files.
- VDU_BASE_ADDR, 'h0200, first VDU page.
- LED_BASE_ADDR, 0, LED latch address.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- core_addr  in  16  CPU address.
- core_write_en  in  1  CPU write strobe.
- core_read_en  in  1  CPU read strobe.
- core_write_data  in  8  CPU write data.
- core_read_data  out  8  CPU read data.
- core_read_valid  out  1  core_read_data valid.
- display_read_en  in  1  display scan strobe.
- display_addr  in  4  digit index.
- display_data_out  out  8  segment data.
- display_data_valid  out  1  display_data_out valid.
- kbd_write_en  in  1  key event strobe.
- kbd_addr  in  4  key row.
- kbd_bit  in  3  key column.
- kbd_pressed  in  1  1 = press, 0 = release.
- vdu_read_en  in  1  VDU fetch strobe.
- vdu_addr  in  16  VDU address.
- vdu_data_out  out  8  VDU byte.
- vdu_data_valid  out  1  vdu_data_out valid.
- leds  out  8  LED latch.

Function
REQ-003 Page = core_addr & 'h0f00.
- ROM: page < 'h200.
- STD RAM: 'hf00.
- EXT RAM: 'hb00.
- DISP/KBD: 'h900 or 'hd00.
- RV0: VDU_BASE_ADDR..'h7ff.
- RV1: core_addr 'h1200..'h17ff.
- Priority follows this order; all other addresses are unmapped.
REQ-004 Read latency SHALL be exactly 1 cycle: the region select is registered alongside the address, and core_read_valid pulses 1 cycle after core_read_en.
REQ-005 Unmapped reads SHALL return 'h00; ROM and unmapped writes SHALL be ignored.
REQ-006 A write to LED_BASE_ADDR SHALL update leds and SHALL NOT touch any digit.
REQ-007 A write to DISP/KBD offset d = core_addr & 'h0f, with d < NUM_DIGITS, SHALL store the segment byte and load that digit's timer with PERSIST_US*CLOCK_FREQ_MHZ; writes with d >= NUM_DIGITS are ignored.
REQ-008 Each digit timer SHALL decrement once per clk and saturate at 0.
REQ-009 Display read SHALL complete in 1 cycle:
- display_addr == LED_BASE_ADDR returns leds.
- Otherwise returns the segment byte if its timer is non-zero, else 'h00.
- Out-of-range index returns 'h00.
- Reads never clear data.
REQ-010 Keyboard rows SHALL be active-low, idle 'hff: a press clears the addressed bit, a release sets it.
REQ-011 With KBD_STICKY=1, a pressed bit SHALL stay 0 until both the key is released and a core read of that row has occurred at or after the release.
REQ-012 A core DISP/KBD read returns the row byte for d < NUM_DIGITS, else 'hff.
REQ-013 Simultaneous-event rules:
- Key event and core read of the same row in one cycle: the read returns the pre-event value.
- Core write and display read of the same digit in one cycle: the display gets the old byte; the timer reload takes effect.
REQ-014 The VDU port SHALL read RV0 RAM with 1-cycle latency, independent of core accesses; out-of-RV0 addresses return 'h00.

Reset
REQ-015 While rst_n=0 the block SHALL hold:
- leds = 0, all digit timers = 0, all segment bytes = 0.
- Keyboard rows = 'hff, sticky flags clear.
- All *_valid = 0, core_read_data / display_data_out = 'h00.
REQ-016 Reset SHALL NOT clear RAM or ROM contents; a reset mid-read SHALL drop that read's valid pulse.

Structure
REQ-017 Package mmu_pkg SHALL hold the region enum and the page constants ('h900, 'hd00, 'hb00, 'hf00, 'h1200, 'h1800).
REQ-018 Digit storage plus timer SHALL be a sub-module digit_persist, instantiated NUM_DIGITS times; memories SHALL reuse the existing bram_sdp / bram_sqp.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Write 'h5a to 'h0903, then display read of digit 3 at 1 us and at PERSIST_US+1 us -> 'h5a then 'h00.
- Write 'h77 to 'hf10, then read 'hf10 -> core_read_data 'h77 with core_read_valid exactly 1 cycle after read_en; read 'h3000 -> 'h00.
- Press row 2 bit 4, release, no read -> core read of 'h0d02 returns 'hef; a second read returns 'hff.
- Write 'h0200 = 'h41 -> VDU read of 'h0200 returns 'h41 while the core concurrently reads ROM.
- rst_n low mid-operation -> leds 'h00, rows 'hff, valids 0, RAM byte at 'hf10 still 'h77.
